multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Main-FSM controller that sequences a shared-resource, multicycle RV32I datapath.
- The datapath has one memory for instructions and data, one ALU, and IR, OldPC, A, WriteData, ALUOut and Data registers.
- Each instruction is broken into fetch, decode, execute, memory and writeback cycles; the controller drives every mux select and write strobe.
- Memory accesses stall on a ready handshake; undecodable opcodes park the controller in a trap state.

Parameters:
- USE_MEM_READY, 1: 1 = FETCH/MEMREAD/MEMWRITE wait for mem_ready; 0 = mem_ready is ignored and treated as 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- op  input  7  IR[6:0].
- funct3  input  3  IR[14:12].
- funct7_5  input  1  IR[30].
- Zero  input  1  ALU zero flag.
- mem_ready  input  1  memory has completed the current access this cycle.
- PCWrite  output  1  load PC.
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  output  1  memory write strobe.
- IRWrite  output  1  load IR and OldPC.
- ResultSrc  output  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  output  2  00 = PC, 01 = OldPC, 10 = A.
- ALUSrcB  output  2  00 = WriteData, 01 = ImmExt, 10 = constant 4.
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- ImmSrc  output  2  00 = I, 01 = S, 10 = B, 11 = J.
- RegWrite  output  1  register-file write strobe.
- illegal  output  1  high while in TRAP.
- state  output  4  current state encoding, for debug.

Behaviour:
- Reset (async, rst_n low):
  - state = FETCH (0).
  - PCWrite, IRWrite, RegWrite and MemWrite are forced 0 while rst_n is low; illegal = 0.
  - Mux selects take their FETCH values.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, ALUWB 7, EXECUTEI 8, JAL 9, BRANCH 10, TRAP 11. Codes 12-15 go to FETCH on the next edge.
- Outputs are Moore-decoded from state, except PCWrite and strobes gated by mem_ready or Zero. Any signal not listed for a state is 0.
- ImmSrc is decoded from op in every state: lw / I-type 00, sw 01, branch 10, jal 11, others 00.
- ALUOp (internal), 00 = add:
  - 01 = sub.
  - 10 = decode funct3: 000 gives sub if {op[5],funct7_5} = 11, else add; 010 slt; 110 or; 111 and; others add.
- FETCH:
  - Outputs: AdrSrc 0, ALUSrcA 00, ALUSrcB 10, ALUOp 00, ResultSrc 10.
  - IRWrite = PCWrite = mem_ready.
  - Next state: DECODE if mem_ready, else stay.
- DECODE:
  - Outputs: ALUSrcA 01, ALUSrcB 01, ALUOp 00 (branch target goes to ALUOut).
  - Next state by op: 0000011/0100011 to MEMADR; 0110011 to EXECUTER; 0010011 to EXECUTEI; 1101111 to JAL; 1100011 to BRANCH; anything else to TRAP.
- MEMADR:
  - Outputs: ALUSrcA 10, ALUSrcB 01, ALUOp 00.
  - Next state: op[5]=0 to MEMREAD, else MEMWRITE.
- MEMREAD:
  - Outputs: AdrSrc 1, ResultSrc 00.
  - Next state: MEMWB on mem_ready, else hold.
- MEMWB:
  - Outputs: ResultSrc 01, RegWrite 1.
  - Next state: FETCH.
- MEMWRITE:
  - Outputs: AdrSrc 1, ResultSrc 00, MemWrite 1 held until acknowledged.
  - Next state: FETCH on mem_ready, else hold.
- EXECUTER:
  - Outputs: ALUSrcA 10, ALUSrcB 00, ALUOp 10.
  - Next state: ALUWB.
- EXECUTEI:
  - Outputs: ALUSrcA 10, ALUSrcB 01, ALUOp 10. The sub qualification applies only when op[5]=1, so addi never subtracts.
  - Next state: ALUWB.
- ALUWB:
  - Outputs: ResultSrc 00, RegWrite 1.
  - Next state: FETCH.
- JAL:
  - Outputs: ALUSrcA 01, ALUSrcB 10, ALUOp 00, ResultSrc 00, PCWrite 1 (PC = target in ALUOut, link = OldPC+4).
  - Next state: ALUWB.
- BRANCH:
  - Outputs: ALUSrcA 10, ALUSrcB 00, ALUOp 01, ResultSrc 00.
  - PCWrite = Zero for funct3 000 (beq), ~Zero for funct3 001 (bne), 0 otherwise.
  - Next state: FETCH.
- TRAP:
  - Outputs: illegal 1; all strobes 0.
  - Next state: stays in TRAP until reset.
- Latency with mem_ready tied high: beq/bne 3 cycles; R, I, sw and jal 4; lw 5. Each mem_ready=0 cycle adds exactly one cycle.
- Reset asserted mid-instruction: state goes to FETCH immediately, asynchronously; strobes drop in the same instant.

Test Plan:
- add (op 0110011, f3 000, f7_5 0), mem_ready=1 -> states 0,1,6,7,0; ALUControl 000 in EXECUTER; RegWrite only in ALUWB.
- sub (f7_5 1), then addi with IR[30]=1 (op 0010011) -> ALUControl 001 for sub, 000 for addi.
- lw with mem_ready low for 2 cycles in MEMREAD -> 7 cycles total; AdrSrc 1 throughout MEMREAD; RegWrite only in MEMWB with ResultSrc 01.
- sw, mem_ready low 1 cycle in FETCH and 1 in MEMWRITE -> IRWrite/PCWrite pulse once, MemWrite high 2 cycles, 6 cycles total.
- beq with Zero=1 -> PCWrite 1 in BRANCH; Zero=0 -> PCWrite 0; bne inverts both; ImmSrc 10.
- op 1110011 -> TRAP (state 11), illegal 1, no strobes for 20 cycles; rst_n pulsed low asynchronously mid-cycle -> state 0 without waiting for a clock edge.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Main-FSM controller for a shared-memory, multicycle RV32I datapath.
//   Each instruction is sequenced through fetch/decode/execute/memory/
//   writeback states. The controller drives every datapath mux select and
//   write strobe.
//
// Ports
//   clk, rst_n      clock (rising edge) and async active-low reset
//   op, funct3,     instruction fields taken from IR
//   funct7_5
//   Zero            ALU zero flag, used to resolve beq/bne
//   mem_ready       memory has finished the current access
//   PCWrite, IRWrite, RegWrite, MemWrite
//                   write strobes, all forced low while reset is asserted
//   AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc
//                   datapath mux selects and ALU function
//   illegal         high while parked in TRAP
//   state           current state, exported for debug
module multicycle_ctrl #(
   parameter bit USE_MEM_READY = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       Zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUControl,
   output logic [1:0] ImmSrc,
   output logic       RegWrite,
   output logic       illegal,
   output logic [3:0] state
);

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMREAD  = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWRITE = 4'd5;
   localparam logic [3:0] S_EXECUTER = 4'd6;
   localparam logic [3:0] S_ALUWB    = 4'd7;
   localparam logic [3:0] S_EXECUTEI = 4'd8;
   localparam logic [3:0] S_JAL      = 4'd9;
   localparam logic [3:0] S_BRANCH   = 4'd10;
   localparam logic [3:0] S_TRAP     = 4'd11;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BR  = 7'b1100011;

   logic [3:0] state_q, state_d;
   logic       rdy;
   logic [1:0] alu_op;
   logic       pcw, irw, regw, memw;

   // With the handshake disabled every memory access completes in one cycle.
   assign rdy = USE_MEM_READY ? mem_ready : 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:    state_d = rdy ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECUTER;
               OP_I:         state_d = S_EXECUTEI;
               OP_JAL:       state_d = S_JAL;
               OP_BR:        state_d = S_BRANCH;
               default:      state_d = S_TRAP;
            endcase
         end
         S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  state_d = rdy ? S_MEMWB : S_MEMREAD;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: state_d = rdy ? S_FETCH : S_MEMWRITE;
         S_EXECUTER: state_d = S_ALUWB;
         S_EXECUTEI: state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_JAL:      state_d = S_ALUWB;
         S_BRANCH:   state_d = S_FETCH;
         S_TRAP:     state_d = S_TRAP;
         default:    state_d = S_FETCH;  // unused codes recover
      endcase
   end

   always_comb begin
      AdrSrc    = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      alu_op    = 2'b00;
      pcw       = 1'b0;
      irw       = 1'b0;
      regw      = 1'b0;
      memw      = 1'b0;
      illegal   = 1'b0;
      case (state_q)
         S_FETCH: begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            irw       = rdy;
            pcw       = rdy;
         end
         // Branch target is computed here so BRANCH can compare rs1/rs2.
         S_DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         S_MEMREAD:  AdrSrc = 1'b1;
         S_MEMWB: begin
            ResultSrc = 2'b01;
            regw      = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc = 1'b1;
            memw   = 1'b1;
         end
         S_EXECUTER: begin
            ALUSrcA = 2'b10;
            alu_op  = 2'b10;
         end
         S_EXECUTEI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            alu_op  = 2'b10;
         end
         S_ALUWB:    regw = 1'b1;
         // ALU forms the link OldPC+4 while PC takes the target from ALUOut.
         S_JAL: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            pcw     = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA = 2'b10;
            alu_op  = 2'b01;
            case (funct3)
               3'b000:  pcw = Zero;
               3'b001:  pcw = ~Zero;
               default: pcw = 1'b0;
            endcase
         end
         S_TRAP:     illegal = 1'b1;
         default: ;
      endcase
   end

   // Strobes drop the instant reset asserts, independent of the clock.
   assign PCWrite  = pcw  & rst_n;
   assign IRWrite  = irw  & rst_n;
   assign RegWrite = regw & rst_n;
   assign MemWrite = memw & rst_n;

   always_comb begin
      ALUControl = 3'b000;
      case (alu_op)
         2'b00: ALUControl = 3'b000;
         2'b01: ALUControl = 3'b001;
         default: begin
            case (funct3)
               // op[5] separates R-type from I-type, so addi never subtracts.
               3'b000:  ALUControl = ({op[5], funct7_5} == 2'b11) ? 3'b001 : 3'b000;
               3'b010:  ALUControl = 3'b101;
               3'b110:  ALUControl = 3'b011;
               3'b111:  ALUControl = 3'b010;
               default: ALUControl = 3'b000;
            endcase
         end
      endcase
   end

   always_comb begin
      case (op)
         OP_SW:   ImmSrc = 2'b01;
         OP_BR:   ImmSrc = 2'b10;
         OP_JAL:  ImmSrc = 2'b11;
         default: ImmSrc = 2'b00;
      endcase
   end

   assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: constant vector table, hand
// sequences for stalls/trap/async reset, and a randomized instruction stream
// checked against an instruction-level model.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] op = 7'h33;
   logic [2:0] funct3 = 3'd0;
   logic       funct7_5 = 1'b0;
   logic       Zero = 1'b0;
   logic       mem_ready = 1'b1;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;
   logic [3:0] state;

   int checks = 0;
   int errors = 0;

   multicycle_ctrl #(.USE_MEM_READY(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7_5(funct7_5),
      .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
      .ImmSrc(ImmSrc), .RegWrite(RegWrite), .illegal(illegal), .state(state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Instruction-level semantics: which ALU operation the instruction means.
   function automatic int sem_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
      if (o == 7'h63) return 1;
      case (f3)
         3'd0:    return (o == 7'h33 && f7) ? 1 : 0;
         3'd2:    return 5;
         3'd6:    return 3;
         3'd7:    return 2;
         default: return 0;
      endcase
   endfunction

   function automatic int sem_imm(input logic [6:0] o);
      case (o)
         7'h23:   return 1;
         7'h63:   return 2;
         7'h6F:   return 3;
         default: return 0;
      endcase
   endfunction

   // Runs one instruction starting from FETCH (called at posedge+1). Phase
   // list comes from the instruction class; stalls are inserted in FETCH
   // and in the memory access phase.
   task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                            input logic z, input int fst, input int mst,
                            input int exp_alu, input int exp_imm, input logic exp_br,
                            output int cycles, output int irw_cnt, output int memw_cnt);
      int ph[$];
      int fs, ms;
      logic acc, waitph;
      op = o; funct3 = f3; funct7_5 = f7; Zero = z;
      case (o)
         7'h03:   ph = '{0, 1, 2, 3, 4};
         7'h23:   ph = '{0, 1, 2, 5};
         7'h33:   ph = '{0, 1, 6, 7};
         7'h13:   ph = '{0, 1, 8, 7};
         7'h6F:   ph = '{0, 1, 9, 7};
         default: ph = '{0, 1, 10};
      endcase
      fs = fst; ms = mst;
      cycles = 0; irw_cnt = 0; memw_cnt = 0;
      foreach (ph[k]) begin
         do begin
            waitph = (ph[k] == 0 || ph[k] == 3 || ph[k] == 5);
            if (ph[k] == 0 && fs > 0) begin mem_ready = 1'b0; fs--; end
            else if (ph[k] != 0 && waitph && ms > 0) begin mem_ready = 1'b0; ms--; end
            else if (waitph) mem_ready = 1'b1;
            else mem_ready = 1'($urandom_range(1));
            acc = !waitph || mem_ready;
            @(negedge clk);
            cycles++;
            irw_cnt += int'(IRWrite);
            memw_cnt += int'(MemWrite);
            chk("state", state, ph[k]);
            chk("IRWrite", IRWrite, ph[k] == 0 && mem_ready);
            chk("PCWrite", PCWrite, (ph[k] == 0 && mem_ready) || ph[k] == 9 || (ph[k] == 10 && exp_br));
            chk("RegWrite", RegWrite, ph[k] == 4 || ph[k] == 7);
            chk("MemWrite", MemWrite, ph[k] == 5);
            chk("AdrSrc", AdrSrc, ph[k] == 3 || ph[k] == 5);
            chk("ImmSrc", ImmSrc, exp_imm);
            chk("illegal", illegal, 0);
            if (ph[k] == 4) chk("ResultSrc_memwb", ResultSrc, 1);
            if (ph[k] == 0) chk("ResultSrc_fetch", ResultSrc, 2);
            if (exp_alu >= 0 && (ph[k] == 6 || ph[k] == 8 || ph[k] == 10))
               chk("ALUControl", ALUControl, exp_alu);
            @(posedge clk); #1;
         end while (!acc);
      end
   endtask

   typedef struct {
      logic [6:0] o;
      logic [2:0] f3;
      logic       f7;
      logic       z;
      int         cyc;
      int         alu;
      int         imm;
      logic       br;
   } vec_t;

   initial begin
      vec_t vt[$];
      int cyc, irw, memw, base, fs, ms;
      logic [6:0] o;
      logic [2:0] f3;
      logic f7, z, br;

      //            op     f3  f7 z  cyc alu imm br
      vt.push_back('{7'h33, 3'd0, 1'b0, 1'b0, 4, 0, 0, 1'b0}); // add
      vt.push_back('{7'h33, 3'd0, 1'b1, 1'b0, 4, 1, 0, 1'b0}); // sub
      vt.push_back('{7'h13, 3'd0, 1'b1, 1'b0, 4, 0, 0, 1'b0}); // addi, IR[30]=1
      vt.push_back('{7'h13, 3'd2, 1'b0, 1'b0, 4, 5, 0, 1'b0}); // slti
      vt.push_back('{7'h33, 3'd6, 1'b0, 1'b0, 4, 3, 0, 1'b0}); // or
      vt.push_back('{7'h13, 3'd7, 1'b0, 1'b0, 4, 2, 0, 1'b0}); // andi
      vt.push_back('{7'h03, 3'd2, 1'b0, 1'b0, 5, -1, 0, 1'b0}); // lw
      vt.push_back('{7'h23, 3'd2, 1'b0, 1'b0, 4, -1, 1, 1'b0}); // sw
      vt.push_back('{7'h63, 3'd0, 1'b0, 1'b1, 3, 1, 2, 1'b1}); // beq taken
      vt.push_back('{7'h63, 3'd0, 1'b0, 1'b0, 3, 1, 2, 1'b0}); // beq not taken
      vt.push_back('{7'h63, 3'd1, 1'b0, 1'b1, 3, 1, 2, 1'b0}); // bne not taken
      vt.push_back('{7'h63, 3'd1, 1'b0, 1'b0, 3, 1, 2, 1'b1}); // bne taken
      vt.push_back('{7'h63, 3'd4, 1'b0, 1'b1, 3, 1, 2, 1'b0}); // blt: never
      vt.push_back('{7'h6F, 3'd0, 1'b0, 1'b0, 4, -1, 3, 1'b0}); // jal

      // Reset state: FETCH selects, strobes low even with mem_ready high.
      #2;
      chk("rst_state", state, 0);
      chk("rst_IRWrite", IRWrite, 0);
      chk("rst_PCWrite", PCWrite, 0);
      chk("rst_ALUSrcB", ALUSrcB, 2);
      chk("rst_ResultSrc", ResultSrc, 2);
      chk("rst_illegal", illegal, 0);
      mem_ready = 1'b0;
      #6 rst_n = 1'b1;
      @(posedge clk); #1;

      foreach (vt[i]) begin
         run_instr(vt[i].o, vt[i].f3, vt[i].f7, vt[i].z, 0, 0,
                   vt[i].alu, vt[i].imm, vt[i].br, cyc, irw, memw);
         chk($sformatf("latency_vec%0d", i), cyc, vt[i].cyc);
      end

      // lw, two stall cycles in MEMREAD.
      run_instr(7'h03, 3'd2, 1'b0, 1'b0, 0, 2, -1, 0, 1'b0, cyc, irw, memw);
      chk("lw_stall_latency", cyc, 7);
      // sw, one stall in FETCH and one in MEMWRITE.
      run_instr(7'h23, 3'd2, 1'b0, 1'b0, 1, 1, -1, 1, 1'b0, cyc, irw, memw);
      chk("sw_stall_latency", cyc, 6);
      chk("sw_irwrite_pulses", irw, 1);
      chk("sw_memwrite_cycles", memw, 2);

      // Illegal opcode parks in TRAP.
      op = 7'h73; funct3 = 3'd0; funct7_5 = 1'b0; mem_ready = 1'b1;
      @(negedge clk); chk("trap_fetch", state, 0);
      @(posedge clk); #1;
      @(negedge clk); chk("trap_decode", state, 1);
      @(posedge clk); #1;
      for (int c = 0; c < 20; c++) begin
         mem_ready = 1'($urandom_range(1));
         Zero = 1'($urandom_range(1));
         @(negedge clk);
         chk("trap_state", state, 11);
         chk("trap_illegal", illegal, 1);
         chk("trap_strobes", {PCWrite, IRWrite, RegWrite, MemWrite}, 0);
         @(posedge clk); #1;
      end
      // Async reset mid-cycle: FETCH without any clock edge.
      mem_ready = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_state", state, 0);
      chk("async_rst_illegal", illegal, 0);
      chk("async_rst_strobes", {PCWrite, IRWrite, RegWrite, MemWrite}, 0);
      mem_ready = 1'b0;
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_state", state, 0);

      // Randomized instruction stream.
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(5))
            0: o = 7'h03;
            1: o = 7'h23;
            2: o = 7'h33;
            3: o = 7'h13;
            4: o = 7'h6F;
            default: o = 7'h63;
         endcase
         f3 = 3'($urandom_range(7));
         f7 = 1'($urandom_range(1));
         z  = 1'($urandom_range(1));
         fs = $urandom_range(2);
         ms = (o == 7'h03 || o == 7'h23) ? $urandom_range(3) : 0;
         br = (o == 7'h63) && ((f3 == 3'd0 && z) || (f3 == 3'd1 && !z));
         base = (o == 7'h03) ? 5 : (o == 7'h63) ? 3 : 4;
         run_instr(o, f3, f7, z, fs, ms,
                   (o == 7'h33 || o == 7'h13 || o == 7'h63) ? sem_alu(o, f3, f7) : -1,
                   sem_imm(o), br, cyc, irw, memw);
         chk("rand_latency", cyc, base + fs + ms);
         chk("rand_irwrite_pulses", irw, 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
